// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the 20-bit CPU.
// Owns pc, the instruction register and trap entry/exit.
//
// state       | meaning
// S_FETCH     | request instruction at pc, wait for mem_ack (bounded)
// S_DECODE    | one cycle; all-zero instruction traps
// S_EXECUTE   | wait for exec_done, then fault / branch / write-back
// S_WRITEBACK | one cycle; pc+1 and retire
// S_TRAP      | trap mode until resume
module stage_sequencer #(
  parameter int INSTR_W       = 20,
  parameter int ADDR_W        = 20,
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               div_by_zero_flag,
  input  logic               mem_violation_flag,
  input  logic               mem_corruption_flag,
  input  logic               resume,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_enable,
  output logic               decode_enable,
  output logic               execute_enable,
  output logic               write_back_enable,
  output logic               trap_mode_flag,
  output logic [2:0]         trap_cause,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_TRAP      = 3'd4;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_TRAPI   = 3'd1;
  localparam logic [2:0] CAUSE_DIV0    = 3'd2;
  localparam logic [2:0] CAUSE_MEMVIOL = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;
  localparam logic [2:0] CAUSE_CORRUPT = 3'd5;

  logic [2:0]      state;
  logic [TO_W-1:0] to_cnt;
  // Holds outputs quiet until the first clock after reset releases.
  logic            running;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      running       <= 1'b0;
      to_cnt        <= '0;
      pc            <= '0;
      instruction   <= '0;
      retired_count <= '0;
      trap_cause    <= CAUSE_NONE;
    end else begin
      running <= 1'b1;
      if (running) begin
        case (state)
          S_FETCH: begin
            if (mem_ack) begin
              instruction <= mem_rdata;
              to_cnt      <= '0;
              state       <= S_DECODE;
            end else if (to_cnt == TO_LAST) begin
              to_cnt     <= '0;
              trap_cause <= CAUSE_TIMEOUT;
              state      <= S_TRAP;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_DECODE: begin
            if (instruction == '0) begin
              trap_cause    <= CAUSE_TRAPI;
              pc            <= pc + ADDR_W'(1);
              retired_count <= retired_count + CNT_W'(1);
              state         <= S_TRAP;
            end else begin
              state <= S_EXECUTE;
            end
          end
          S_EXECUTE: begin
            if (exec_done) begin
              if (mem_corruption_flag) begin
                trap_cause <= CAUSE_CORRUPT;
                state      <= S_TRAP;
              end else if (mem_violation_flag) begin
                trap_cause <= CAUSE_MEMVIOL;
                state      <= S_TRAP;
              end else if (div_by_zero_flag) begin
                trap_cause <= CAUSE_DIV0;
                state      <= S_TRAP;
              end else if (branch_taken) begin
                pc            <= branch_target;
                retired_count <= retired_count + CNT_W'(1);
                state         <= S_FETCH;
              end else begin
                state <= S_WRITEBACK;
              end
            end
          end
          S_WRITEBACK: begin
            pc            <= pc + ADDR_W'(1);
            retired_count <= retired_count + CNT_W'(1);
            state         <= S_FETCH;
          end
          S_TRAP: begin
            if (resume) begin
              trap_cause <= CAUSE_NONE;
              state      <= S_FETCH;
            end
          end
          default: state <= S_FETCH;
        endcase
      end
    end
  end

  assign fetch_enable      = running && (state == S_FETCH);
  assign decode_enable     = running && (state == S_DECODE);
  assign execute_enable    = running && (state == S_EXECUTE);
  assign write_back_enable = running && (state == S_WRITEBACK);
  assign trap_mode_flag    = running && (state == S_TRAP);
  assign mem_req           = fetch_enable;
  assign mem_addr          = pc;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus pushes expected snapshots,
// a negedge monitor pops one each time FETCH or TRAP is entered.
module tb_stage_sequencer;
  localparam int IW = 20;
  localparam int AW = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          exec_done = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          div_by_zero_flag = 1'b0;
  logic          mem_violation_flag = 1'b0;
  logic          mem_corruption_flag = 1'b0;
  logic          resume = 1'b0;
  logic [IW-1:0] instruction;
  logic [AW-1:0] pc;
  logic          fetch_enable, decode_enable, execute_enable, write_back_enable;
  logic          trap_mode_flag;
  logic [2:0]    trap_cause;
  logic [CW-1:0] retired_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit            is_trap;
    logic [AW-1:0] pc;
    logic [CW-1:0] ret;
    logic [2:0]    cause;
    logic [IW-1:0] instr;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_e;
  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_ret;
  logic          prev_f = 1'b0;
  logic          prev_t = 1'b0;

  stage_sequencer dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .div_by_zero_flag(div_by_zero_flag), .mem_violation_flag(mem_violation_flag),
    .mem_corruption_flag(mem_corruption_flag), .resume(resume),
    .instruction(instruction), .pc(pc),
    .fetch_enable(fetch_enable), .decode_enable(decode_enable),
    .execute_enable(execute_enable), .write_back_enable(write_back_enable),
    .trap_mode_flag(trap_mode_flag), .trap_cause(trap_cause), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_stage(input string name, input logic [3:0] exp);
    check({name, "_stage"},
          {28'd0, fetch_enable, decode_enable, execute_enable, write_back_enable}, {28'd0, exp});
    check({name, "_mem_req"}, {31'd0, mem_req}, {31'd0, exp[3]});
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit t, input logic [2:0] cause, input logic [IW-1:0] ins);
    ev_t e;
    e.is_trap = t;
    e.pc      = m_pc;
    e.ret     = m_ret;
    e.cause   = cause;
    e.instr   = ins;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected snapshot per entry into FETCH or TRAP.
  always @(negedge clk) begin
    if ((fetch_enable && !prev_f) || (trap_mode_flag && !prev_t)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got pc=0x%0h trap=%0b, expected no event", pc, trap_mode_flag);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_kind", {31'd0, trap_mode_flag}, {31'd0, mon_e.is_trap});
        check("ev_pc", {12'd0, pc}, {12'd0, mon_e.pc});
        check("ev_mem_addr", {12'd0, mem_addr}, {12'd0, mon_e.pc});
        check("ev_retired", {16'd0, retired_count}, {16'd0, mon_e.ret});
        check("ev_cause", {29'd0, trap_cause}, {29'd0, mon_e.cause});
        check("ev_instr", {12'd0, instruction}, {12'd0, mon_e.instr});
      end
    end
    prev_f <= fetch_enable;
    prev_t <= trap_mode_flag;
  end

  // Starts at a FETCH-cycle negedge, ends at the next FETCH-cycle negedge.
  task automatic run_normal(input string name, input logic [IW-1:0] ins, input int ack_wait,
                            input int exec_wait, input bit br, input logic [AW-1:0] tgt);
    mem_rdata     = ins;
    mem_ack       = (ack_wait == 0);
    exec_done     = (exec_wait == 0);
    branch_taken  = br;
    branch_target = tgt;
    if (br) m_pc = tgt;
    else m_pc = m_pc + AW'(1);
    m_ret = m_ret + CW'(1);
    push(1'b0, 3'd0, ins);
    for (int i = 0; i < ack_wait; i++) begin
      step();
      check_stage({name, "_fwait"}, 4'b1000);
    end
    mem_ack = 1'b1;
    step();
    check_stage({name, "_dec"}, 4'b0100);
    check({name, "_instr"}, {12'd0, instruction}, {12'd0, ins});
    step();
    check_stage({name, "_exe"}, 4'b0010);
    for (int i = 0; i < exec_wait; i++) begin
      div_by_zero_flag    = 1'b1;
      mem_violation_flag  = 1'b1;
      mem_corruption_flag = 1'b1;
      branch_taken        = 1'b1;
      step();
      check_stage({name, "_ewait"}, 4'b0010);
    end
    div_by_zero_flag    = 1'b0;
    mem_violation_flag  = 1'b0;
    mem_corruption_flag = 1'b0;
    branch_taken        = br;
    exec_done           = 1'b1;
    step();
    if (!br) begin
      check_stage({name, "_wb"}, 4'b0001);
      step();
    end
    check_stage({name, "_next"}, 4'b1000);
    check({name, "_pc"}, {12'd0, pc}, {12'd0, m_pc});
    branch_taken = 1'b0;
  endtask

  task automatic do_resume(input string name, input logic [IW-1:0] ins);
    resume = 1'b0;
    step(2);
    check({name, "_trap_hold"}, {31'd0, trap_mode_flag}, 32'd1);
    check_stage({name, "_trap_quiet"}, 4'b0000);
    push(1'b0, 3'd0, ins);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check_stage({name, "_resumed"}, 4'b1000);
    check({name, "_cause_clr"}, {29'd0, trap_cause}, 32'd0);
  endtask

  task automatic run_fault(input string name, input logic [IW-1:0] ins, input bit d, input bit v,
                           input bit c, input logic [2:0] cause);
    mem_rdata = ins;
    mem_ack   = 1'b1;
    exec_done = 1'b1;
    div_by_zero_flag    = d;
    mem_violation_flag  = v;
    mem_corruption_flag = c;
    push(1'b1, cause, ins);
    step();
    check_stage({name, "_dec"}, 4'b0100);
    step();
    check_stage({name, "_exe"}, 4'b0010);
    step();
    check_stage({name, "_trap"}, 4'b0000);
    check({name, "_trap_flag"}, {31'd0, trap_mode_flag}, 32'd1);
    div_by_zero_flag    = 1'b0;
    mem_violation_flag  = 1'b0;
    mem_corruption_flag = 1'b0;
    do_resume(name, ins);
  endtask

  initial begin
    m_pc  = '0;
    m_ret = '0;
    #3;
    check("rst_pc", {12'd0, pc}, 32'd0);
    check_stage("rst", 4'b0000);
    step(2);
    check_stage("rst_held", 4'b0000);
    check("rst_trap", {31'd0, trap_mode_flag}, 32'd0);
    check("rst_retired", {16'd0, retired_count}, 32'd0);
    push(1'b0, 3'd0, 20'h0);
    mem_ack = 1'b1;
    reset   = 1'b0;
    step();
    check_stage("first_fetch", 4'b1000);

    run_normal("basic", 20'h26502, 0, 0, 1'b0, 20'h0);
    check("basic_pc1", {12'd0, pc}, 32'd1);
    check("basic_ret1", {16'd0, retired_count}, 32'd1);

    // All-zero instruction: pc advances and retires, then traps.
    mem_rdata = 20'h0;
    m_pc  = m_pc + AW'(1);
    m_ret = m_ret + CW'(1);
    push(1'b1, 3'd1, 20'h0);
    step();
    check_stage("trapi_dec", 4'b0100);
    step();
    check_stage("trapi_trap", 4'b0000);
    check("trapi_pc", {12'd0, pc}, 32'd2);
    do_resume("trapi", 20'h0);

    run_normal("branch", 20'h0C800, 0, 0, 1'b1, 20'h0ABCD);
    check("branch_addr", {12'd0, mem_addr}, 32'h0ABCD);

    run_fault("div_viol", 20'h12345, 1'b1, 1'b1, 1'b0, 3'd3);
    check("div_viol_ret", {16'd0, retired_count}, 32'd3);
    run_fault("all_faults", 20'h12346, 1'b1, 1'b1, 1'b1, 3'd5);
    run_fault("div_only", 20'h12347, 1'b1, 1'b0, 1'b0, 3'd2);

    run_normal("exec_wait", 20'h55555, 0, 3, 1'b0, 20'h0);
    run_normal("ack_c15", 20'h0F00F, 14, 0, 1'b0, 20'h0);

    // Timeout: FETCH cycles 1..15 without ack, TRAP in cycle 16.
    mem_ack = 1'b0;
    push(1'b1, 3'd4, 20'h0F00F);
    for (int i = 2; i <= 15; i++) begin
      step();
      check_stage("timeout_wait", 4'b1000);
    end
    step();
    check_stage("timeout_trap", 4'b0000);
    check("timeout_cause", {29'd0, trap_cause}, 32'd4);
    do_resume("timeout", 20'h0F00F);

    run_normal("to_max", 20'h00777, 0, 0, 1'b1, 20'hFFFFF);
    run_normal("wrap", 20'h00888, 0, 0, 1'b0, 20'h0);
    check("wrap_pc0", {12'd0, pc}, 32'd0);

    // Asynchronous reset in the middle of EXECUTE.
    mem_rdata = 20'h11111;
    mem_ack   = 1'b1;
    exec_done = 1'b0;
    step();
    step();
    check_stage("areset_exe", 4'b0010);
    #2 reset = 1'b1;
    #1;
    check_stage("areset", 4'b0000);
    check("areset_pc", {12'd0, pc}, 32'd0);
    check("areset_instr", {12'd0, instruction}, 32'd0);
    check("areset_ret", {16'd0, retired_count}, 32'd0);
    check("areset_trap", {28'd0, trap_mode_flag, trap_cause}, 32'd0);
    m_pc  = '0;
    m_ret = '0;
    push(1'b0, 3'd0, 20'h0);
    step();
    reset = 1'b0;
    step();
    check_stage("after_areset", 4'b1000);
    check("after_areset_addr", {12'd0, mem_addr}, 32'd0);

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
